// File: rtl/bus_pkg.sv
// Shared constants and helpers for the 32-bit datapath bus.
package bus_pkg;

    localparam int unsigned BUS_WIDTH    = 32;
    localparam int unsigned DEFAULT_SRCS = 8;
    localparam int unsigned MAX_SRCS     = 32;

    // One-hot vector with bit idx set; callers truncate to their source count.
    function automatic logic [MAX_SRCS-1:0] onehot(input int unsigned idx);
        return MAX_SRCS'(1) << idx;
    endfunction

    // idx + 1 modulo n, written as an explicit compare so non-power-of-2 n wraps correctly.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bus_arb_mux_rr_arbiter.sv
// Combinational round-robin arbiter with owner lock override.
module rr_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned N    = DEFAULT_SRCS,
    parameter int unsigned SELW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [SELW-1:0] pointer_i,
    input  logic            lock_held_i,
    input  logic [SELW-1:0] owner_i,
    output logic [N-1:0]    grant_o,
    output logic [SELW-1:0] winner_o
);

    logic [N-1:0] req_rot;
    logic         found;
    int unsigned  offset;
    int unsigned  sum;

    // Rotate the doubled request vector so the pointer lands on bit 0, take the
    // first set bit, then map the offset back to a source index modulo N.
    always_comb begin
        req_rot = N'({req_i, req_i} >> pointer_i);
        found   = 1'b0;
        offset  = 0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && req_rot[k]) begin
                found  = 1'b1;
                offset = k;
            end
        end
        sum = 32'(pointer_i) + offset;
        if (sum >= N) begin
            sum = sum - N;
        end
        if (lock_held_i && req_i[owner_i]) begin
            winner_o = owner_i;
        end else begin
            winner_o = SELW'(sum);
        end
        grant_o = (|req_i) ? N'(onehot(32'(winner_o))) : '0;
    end

endmodule

// File: rtl/bus_arb_mux.sv
// Registered N-source bus multiplexer with round-robin arbitration and owner lock.
module bus_arb_mux
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH = BUS_WIDTH,
    parameter int unsigned N     = DEFAULT_SRCS,
    parameter int unsigned SELW  = $clog2(N)
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [N-1:0]       src_req,
    input  logic [N-1:0]       src_lock,
    input  logic [N*WIDTH-1:0] src_data,
    output logic [N-1:0]       src_grant,
    input  logic               bus_ready,
    output logic               bus_valid,
    output logic [WIDTH-1:0]   bus_data,
    output logic [SELW-1:0]    bus_owner
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SELW-1:0]  owner_q, owner_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic             lock_q, lock_d;

    logic             load;
    logic [N-1:0]     arb_grant;
    logic [SELW-1:0]  winner;
    logic [WIDTH-1:0] sel_data;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req_i       (src_req),
        .pointer_i   (ptr_q),
        .lock_held_i (lock_q),
        .owner_i     (owner_q),
        .grant_o     (arb_grant),
        .winner_o    (winner)
    );

    // Load when the output stage is empty or being drained and someone is asking.
    always_comb begin
        load      = !clear && (!valid_q || bus_ready) && (|src_req);
        src_grant = load ? arb_grant : '0;
    end

    // AND-OR select keyed on the grant so unrequested lanes never propagate.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sel_data = sel_data | (src_data[i*WIDTH +: WIDTH] & {WIDTH{src_grant[i]}});
        end
    end

    // Next-state for the output stage, rr pointer and lock flag.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = sel_data;
            owner_d = winner;
            ptr_d   = SELW'(wrap_inc(32'(winner), N));
            lock_d  = src_lock[winner];
        end else if (bus_ready && valid_q) begin
            valid_d = 1'b0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            lock_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
        end
    end

    assign bus_valid = valid_q;
    assign bus_data  = data_q;
    assign bus_owner = owner_q;

endmodule
